// File: rtl/bcd_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_pkg : shared BCD/binary conversion constants, state encoding and helpers
// rev 1.0 : initial release
// -----------------------------------------------------------------------------
package bcd_pkg;

  localparam int DIGITS = 9;
  localparam int BIN_W  = 30;
  localparam int OUT_W  = 36;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = $clog2(BIN_W);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIN_W - 1);
  localparam logic [3:0]       SUB3      = 4'd3;
  localparam logic [3:0]       DIGIT_MAX = 4'd9;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A packed BCD word is usable only when every nibble is a decimal digit.
  function automatic logic digits_valid(input logic [BCD_W-1:0] bcd);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_sub3_digit.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_sub3_digit : reverse double-dabble correction cell (>=8 ? -3 : pass)
// rev 1.0 : initial release
// -----------------------------------------------------------------------------
module bcd_sub3_digit
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd8) digit_o = digit_i - SUB3;
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_binary_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_to_binary_seq : sequential 9-digit BCD to binary converter, one bit/cycle
// rev 1.0 : initial release
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
  import bcd_pkg::*;
(
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       BCD0,
  input  logic [3:0]       BCD1,
  input  logic [3:0]       BCD2,
  input  logic [3:0]       BCD3,
  input  logic [3:0]       BCD4,
  input  logic [3:0]       BCD5,
  input  logic [3:0]       BCD6,
  input  logic [3:0]       BCD7,
  input  logic [3:0]       BCD8,
  output logic [OUT_W-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int SH_W = BCD_W + BIN_W;

  state_t            state_q, state_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic [BCD_W-1:0]  bcd_in;
  logic [SH_W-1:0]   shifted;
  logic [SH_W-1:0]   shifted_corr;

  assign bcd_in  = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
  assign shifted = sh_q >> 1;

  // Every digit of the shifted bcd field is corrected in the same cycle.
  assign shifted_corr[BIN_W-1:0] = shifted[BIN_W-1:0];
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_sub3
    bcd_sub3_digit u_sub3 (
      .digit_i (shifted[BIN_W + 4*gi +: 4]),
      .digit_o (shifted_corr[BIN_W + 4*gi +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!digits_valid(bcd_in)) begin
            error_d = 1'b1;
          end else begin
            sh_d    = {bcd_in, {BIN_W{1'b0}}};
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sh_d  = shifted_corr;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          data_d  = {{(OUT_W-BIN_W){1'b0}}, shifted_corr[BIN_W-1:0]};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign data  = data_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_binary_seq.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq : scoreboard bench for the BCD to binary converter
// rev 1.0 : initial release
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

  localparam int LATENCY = 30;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [3:0]  BCD0, BCD1, BCD2, BCD3, BCD4, BCD5, BCD6, BCD7, BCD8;
  logic [35:0] data;
  logic        busy, done, error;

  always #5 Clk = ~Clk;

  bcd_to_binary_seq dut (
    .Clk   (Clk),
    .Reset (Reset),
    .start (start),
    .BCD0  (BCD0),
    .BCD1  (BCD1),
    .BCD2  (BCD2),
    .BCD3  (BCD3),
    .BCD4  (BCD4),
    .BCD5  (BCD5),
    .BCD6  (BCD6),
    .BCD7  (BCD7),
    .BCD8  (BCD8),
    .data  (data),
    .busy  (busy),
    .done  (done),
    .error (error)
  );

  typedef struct {
    bit          is_err;
    logic [35:0] data;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [35:0] last_data;
  int          checks = 0;
  int          errors = 0;
  int          busy_run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Decimal value of a packed BCD word, nibble 0 least significant.
  function automatic logic [35:0] ref_value(input logic [35:0] d);
    longint v = 0;
    for (int i = 8; i >= 0; i--) v = v * 10 + longint'(d[4*i +: 4]);
    return v[35:0];
  endfunction

  function automatic bit ref_valid(input logic [35:0] d);
    for (int i = 0; i < 9; i++) if (d[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_digits(input logic [35:0] d);
    BCD0 = d[3:0];   BCD1 = d[7:4];   BCD2 = d[11:8];
    BCD3 = d[15:12]; BCD4 = d[19:16]; BCD5 = d[23:20];
    BCD6 = d[27:24]; BCD7 = d[31:28]; BCD8 = d[35:32];
  endtask

  task automatic issue(input logic [35:0] d);
    exp_t e;
    drive_digits(d);
    start = 1'b1;
    if (ref_valid(d)) begin
      e.is_err  = 1'b0;
      e.data    = ref_value(d);
      last_data = e.data;
    end else begin
      e.is_err = 1'b1;
      e.data   = last_data;
    end
    q.push_back(e);
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge Clk);
      #1;
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  function automatic logic [35:0] rand_digits(input bit allow_bad);
    logic [35:0] d;
    for (int i = 0; i < 9; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && ($urandom_range(0, 7) == 0))
      d[4*$urandom_range(0, 8) +: 4] = 4'($urandom_range(10, 15));
    return d;
  endfunction

  // Monitor: pops one expectation per done/error pulse.
  always @(negedge Clk) begin
    if (Reset) begin
      busy_run = 0;
    end else begin
      if (done && error) check("done_and_error", 64'd1, 64'd0);
      if (done || error) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", {62'd0, done, error}, 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("pulse_kind", 64'(error), 64'(mon_e.is_err));
          check("data", 64'(data), 64'(mon_e.data));
          if (done) begin
            check("busy_cycles", 64'(busy_run), 64'(LATENCY));
            check("bcd_field_zero", 64'(dut.sh_q[65:30]), 64'd0);
          end else begin
            check("busy_on_error", 64'(busy), 64'd0);
          end
        end
      end
      if (busy) busy_run++;
      else      busy_run = 0;
    end
  end

  initial begin
    Reset = 1'b1;
    start = 1'b0;
    last_data = '0;
    drive_digits(36'h0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_data", 64'(data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);

    issue(36'h000000000);
    drain();
    check("data_zero", 64'(data), 64'd0);

    issue(36'h999999999);
    drain();
    check("data_999999999", 64'(data), 64'h03B9AC9FF);

    issue(36'h012345678);
    drain();
    check("data_12345678", 64'(data), 64'h000BC614E);
    issue(36'h000000001);
    drain();
    check("data_one", 64'(data), 64'd1);

    issue(36'h1234A5678);
    drain();
    check("data_after_error", 64'(data), 64'd1);
    check("busy_after_error", 64'(busy), 64'd0);

    // Start pulse and digit changes mid-conversion must be ignored.
    issue(36'h987654321);
    repeat (5) @(posedge Clk);
    #1 start = 1'b1;
    drive_digits(36'h111111111);
    @(posedge Clk);
    #1 start = 1'b0;
    drive_digits(36'h555555555);
    drain();
    repeat (5) @(posedge Clk);
    check("data_ignore_start", 64'(data), 64'd987654321);

    // Reset in the middle of a conversion.
    issue(36'h123456789);
    repeat (14) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    q.delete();
    last_data = '0;
    check("midrst_data", 64'(data), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    issue(36'h000031415);
    drain();

    for (int k = 0; k < 25; k++) begin
      issue(rand_digits(1'b1));
      drain();
    end

    repeat (5) @(posedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
